// File: rtl/rv32i_fetch.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_fetch
// Description : RV32I instruction fetch stage. Issues sequential word fetches
//               to instruction memory, pairs the in-order responses with their
//               PCs in a small slot FIFO, and presents {pc, inst} to decode
//               over a valid/ready handshake. A redirect restarts fetch at a
//               new PC, frees every slot and arranges for responses to
//               requests already in flight to be discarded.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32i_fetch #(
  parameter logic [31:0] START_ADDR      = 32'h0000_0000,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_data
);

  // Pointers carry one bit beyond the slot index so full and empty differ.
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int IDX_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W:0]   MAX_EXT  = (CNT_W + 1)'(MAX_OUTSTANDING);
  localparam logic [IDX_W-1:0] IDX_MASK = IDX_W'(MAX_OUTSTANDING - 1);

  // Slot storage. Entries between head and fill hold a returned instruction;
  // entries between fill and tail are still waiting for memory.
  logic [31:0]      r_pc_mem   [MAX_OUTSTANDING];
  logic [31:0]      r_data_mem [MAX_OUTSTANDING];

  logic [31:0]      r_pc;
  logic [CNT_W-1:0] r_head;
  logic [CNT_W-1:0] r_fill;
  logic [CNT_W-1:0] r_tail;
  logic [CNT_W-1:0] r_drop;

  logic [CNT_W-1:0] w_used;
  logic [CNT_W-1:0] w_unfilled;
  logic [CNT_W:0]   w_credit_sum;
  logic [CNT_W:0]   w_drop_sum;
  logic [CNT_W-1:0] w_drop_redirect;
  logic             w_head_filled;
  logic             w_req_fire;
  logic             w_pop;
  logic             w_fill;
  logic             w_drop_resp;
  logic             w_unused_addr_lsb;

  // Map a wide pointer onto a slot index (slot count is a power of two).
  function automatic logic [IDX_W-1:0] slot_idx(input logic [CNT_W-1:0] ptr);
    return IDX_W'(ptr) & IDX_MASK;
  endfunction

  assign w_unused_addr_lsb = ^redirect_addr[1:0];

  assign w_used        = r_tail - r_head;
  assign w_unfilled    = r_tail - r_fill;
  assign w_head_filled = (r_head != r_fill);

  // Credit counts both live slots and stale responses still owed by memory,
  // so a slot is never reused while a discarded response could land in it.
  assign w_credit_sum  = {1'b0, w_used} + {1'b0, r_drop};

  assign imem_req_valid = !rst && !redirect_valid && (w_credit_sum < MAX_EXT);
  assign imem_req_addr  = r_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign inst_valid = !rst && !redirect_valid && w_head_filled;
  assign inst_pc    = r_pc_mem[slot_idx(r_head)];
  assign inst_data  = r_data_mem[slot_idx(r_head)];
  assign w_pop      = inst_valid && inst_ready;

  // A response first cancels a stale request, otherwise fills the oldest
  // waiting slot.
  assign w_drop_resp = imem_resp_valid && (r_drop != '0);
  assign w_fill      = imem_resp_valid && (r_drop == '0) && (w_unfilled != '0);

  // On redirect every waiting slot becomes a stale request; a response
  // arriving in the same cycle retires one of those immediately.
  assign w_drop_sum      = {1'b0, r_drop} + {1'b0, w_unfilled};
  assign w_drop_redirect = (imem_resp_valid && (w_drop_sum != '0))
                         ? CNT_W'(w_drop_sum - (CNT_W + 1)'(1))
                         : CNT_W'(w_drop_sum);

  // Control state: PC, FIFO pointers and stale-response count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc   <= START_ADDR;
      r_head <= '0;
      r_fill <= '0;
      r_tail <= '0;
      r_drop <= '0;
    end else if (redirect_valid) begin
      r_pc   <= {redirect_addr[31:2], 2'b00};
      r_head <= r_tail;
      r_fill <= r_tail;
      r_drop <= w_drop_redirect;
    end else begin
      if (w_req_fire) begin
        r_pc   <= r_pc + 32'd4;
        r_tail <= r_tail + CNT_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + CNT_W'(1);
      end
      if (w_fill) begin
        r_fill <= r_fill + CNT_W'(1);
      end
      if (w_drop_resp) begin
        r_drop <= r_drop - CNT_W'(1);
      end
    end
  end

  // Slot payload: PC captured at request time, instruction at response time.
  always_ff @(posedge clk) begin
    if (w_req_fire) begin
      r_pc_mem[slot_idx(r_tail)] <= r_pc;
    end
    if (w_fill && !redirect_valid) begin
      r_data_mem[slot_idx(r_fill)] <= imem_resp_data;
    end
  end

`ifndef SYNTHESIS
  // A response must either cancel a stale request or land in a waiting slot.
  always_ff @(posedge clk) begin
    if (!rst && imem_resp_valid) begin
      assert ((r_drop != '0) || (w_unfilled != '0));
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rv32i_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32i_fetch
// Description : Self-checking bench for rv32i_fetch. A memory model answers
//               requests in order; the reference model is the architectural
//               instruction stream (target, target+4, ...) restarted by every
//               redirect or reset, paired with an address-derived word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32i_fetch;

  localparam logic [31:0] START = 32'h0000_0000;
  localparam int          MAXO  = 2;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;

  rv32i_fetch #(
    .START_ADDR      (START),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_addr   (redirect_addr),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_pc         (inst_pc),
    .inst_data       (inst_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks;
  int          n_fail;
  int          delivered;
  int          fire_count;
  logic [31:0] exp_q [$];
  logic [31:0] exp_last;
  logic [31:0] mem_q [$];
  logic [31:0] fetch_pc;
  logic        req_pending;
  logic [31:0] pend_addr;
  logic        mon_stalled;
  logic [31:0] mon_pc;
  logic [31:0] mon_data;
  logic [31:0] mon_e;

  // Instruction word stored at an address in the memory model.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic top_up();
    while (exp_q.size() < 128) begin
      exp_last = exp_last + 32'd4;
      exp_q.push_back(exp_last);
    end
  endtask

  task automatic restart_stream(input logic [31:0] target);
    exp_q.delete();
    exp_last = target - 32'd4;
    top_up();
    fetch_pc = target;
  endtask

  task automatic do_reset(input int cyc);
    rst             = 1'b1;
    imem_resp_valid = 1'b0;
    redirect_valid  = 1'b0;
    imem_req_ready  = 1'b0;
    #1;
    check("rst_inst_valid", inst_valid, 0);
    check("rst_req_valid", imem_req_valid, 0);
    mem_q.delete();
    restart_stream(START);
    req_pending = 1'b0;
    repeat (cyc) @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock of stimulus; request-side checks happen just after driving.
  task automatic one_cycle(input bit redir, input logic [31:0] raddr,
                           input bit rdy, input bit irdy, input bit resp);
    @(negedge clk);
    redirect_valid = redir;
    redirect_addr  = raddr;
    imem_req_ready = rdy;
    inst_ready     = irdy;
    if (resp && mem_q.size() > 0) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = imem_word(mem_q.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
    #1;
    if (redir) begin
      check("req_valid_in_redirect", imem_req_valid, 0);
      restart_stream(raddr & 32'hFFFF_FFFC);
    end else begin
      if (req_pending) begin
        check("req_held_valid", imem_req_valid, 1);
        check("req_held_addr", imem_req_addr, pend_addr);
      end
      if (imem_req_valid && imem_req_ready) begin
        check("req_addr", imem_req_addr, fetch_pc);
        fetch_pc = fetch_pc + 32'd4;
        mem_q.push_back(imem_req_addr);
        fire_count++;
        n_checks++;
        if (mem_q.size() > MAXO) begin
          n_fail++;
          $display("FAIL inflight: got %0d requests outstanding, limit %0d", mem_q.size(), MAXO);
        end
      end
    end
    req_pending = !redir && imem_req_valid && !imem_req_ready;
    pend_addr   = imem_req_addr;
    top_up();
  endtask

  // Monitor: every handshake to decode pops the next expected instruction.
  initial begin
    mon_stalled = 1'b0;
    mon_pc      = '0;
    mon_data    = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        mon_stalled = 1'b0;
      end else begin
        if (redirect_valid) begin
          check("inst_valid_in_redirect", inst_valid, 0);
        end else if (mon_stalled) begin
          check("stall_valid", inst_valid, 1);
          check("stall_pc", inst_pc, mon_pc);
          check("stall_data", inst_data, mon_data);
        end
        if (inst_valid && inst_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL inst_unexpected: got pc %h expected no instruction", inst_pc);
          end else begin
            mon_e = exp_q.pop_front();
            check("inst_pc", inst_pc, mon_e);
            check("inst_data", inst_data, imem_word(mon_e));
            delivered++;
          end
        end
        mon_stalled = inst_valid && !inst_ready;
        mon_pc      = inst_pc;
        mon_data    = inst_data;
      end
    end
  end

  int d0;

  initial begin
    n_checks = 0; n_fail = 0; delivered = 0; fire_count = 0;
    imem_resp_data = '0; redirect_addr = '0; inst_ready = 1'b0;
    do_reset(3);

    // Streaming with an always-ready memory and decode.
    d0 = delivered;
    repeat (40) one_cycle(0, 0, 1, 1, 1);
    check("stream_throughput", (delivered - d0) >= 15, 1);

    // Decode stalled straight after reset: only the slot count is fetched.
    @(negedge clk);
    do_reset(2);
    fire_count = 0;
    repeat (10) one_cycle(0, 0, 1, 0, 1);
    check("stall_fire_count", fire_count, MAXO);
    check("stall_req_valid", imem_req_valid, 0);
    check("stall_inst_valid", inst_valid, 1);
    check("stall_inst_pc", inst_pc, START);
    repeat (20) one_cycle(0, 0, 1, 1, 1);

    // Asynchronous reset in the middle of a cycle while output is valid.
    repeat (6) one_cycle(0, 0, 1, 0, 1);
    check("prereset_inst_valid", inst_valid, 1);
    #2;
    do_reset(2);

    // Two requests in flight, redirect to an unaligned target.
    one_cycle(1, 32'h10, 1, 1, 0);
    repeat (3) one_cycle(0, 0, 1, 1, 0);
    check("inflight_before_redirect", mem_q.size(), 2);
    one_cycle(1, 32'h103, 1, 1, 1);
    repeat (20) one_cycle(0, 0, 1, 1, 1);

    // Redirect coinciding with a response and a presentable instruction.
    one_cycle(1, 32'h200, 1, 1, 1);
    repeat (20) one_cycle(0, 0, 1, 1, 1);
    one_cycle(1, 32'h200, 1, 1, 1);
    one_cycle(0, 0, 1, 1, 1);
    one_cycle(0, 0, 1, 1, 1);
    one_cycle(1, 32'h300, 1, 1, 1);
    repeat (20) one_cycle(0, 0, 1, 1, 1);

    // Memory stall with a redirect arriving mid-stall.
    one_cycle(1, 32'h20, 1, 1, 1);
    repeat (3) one_cycle(0, 0, 0, 1, 0);
    one_cycle(1, 32'h40, 0, 1, 0);
    repeat (2) one_cycle(0, 0, 0, 1, 0);
    repeat (20) one_cycle(0, 0, 1, 1, 1);

    // PC wraps from the top of the address space.
    one_cycle(1, 32'hFFFF_FFF8, 1, 1, 1);
    repeat (20) one_cycle(0, 0, 1, 1, 1);

    // Randomized traffic with back-to-back redirects.
    for (int i = 0; i < 3000; i++) begin
      logic        rd;
      logic [31:0] ra;
      rd = ($urandom_range(0, 11) == 0);
      ra = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                       : ($urandom & 32'h0000_FFFF);
      one_cycle(rd, ra, $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
                $urandom_range(0, 9) < 6);
    end

    // Everything open: the stream must keep flowing.
    d0 = delivered;
    repeat (60) one_cycle(0, 0, 1, 1, 1);
    check("drain_progress", (delivered - d0) >= 20, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
